// File: rtl/aes_byte_loader.sv
// Feeds one key/plaintext pair to the 8-bit serial AES core: reset pulse, 16-byte load, then wait
// for the core's d_vld (or a timeout) before accepting the next pair.
module aes_byte_loader #(
    parameter int RST_CYC   = 2,
    parameter int TIMEOUT   = 1023,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_key,
    input  logic [127:0] in_data,
    output logic         core_rst,
    output logic [7:0]   key_byte,
    output logic [7:0]   data_byte,
    output logic         load_act,
    input  logic         core_vld,
    output logic         done,
    output logic         timeout,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CRST,
        S_LOAD,
        S_WAIT
    } state_t;

    localparam logic [9:0] RST_LAST = 10'(RST_CYC - 1);
    localparam logic [9:0] TO_LAST  = 10'(TIMEOUT - 1);

    state_t       state;
    state_t       state_nxt;
    logic [9:0]   cnt;
    logic [9:0]   cnt_nxt;
    logic [127:0] key_reg;
    logic [127:0] data_reg;
    logic         vld_prev;
    logic         vld_rise;
    logic         accept;
    logic         byte_ld;
    logic [3:0]   byte_idx;

    function automatic logic [7:0] pick_byte(input logic [127:0] blk, input logic [3:0] idx);
        logic [3:0]   pos;
        logic [127:0] sh;
        pos = MSB_FIRST ? (4'd15 - idx) : idx;
        sh  = blk >> {pos, 3'b000};
        return sh[7:0];
    endfunction

    assign vld_rise = core_vld & ~vld_prev;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        byte_ld   = 1'b0;
        byte_idx  = 4'd0;
        done      = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    cnt_nxt   = 10'd0;
                    state_nxt = S_CRST;
                end
            end
            S_CRST: begin
                // Byte 0 is registered on the way out so it lines up with the first core_rst-low cycle.
                if (cnt == RST_LAST) begin
                    state_nxt = S_LOAD;
                    cnt_nxt   = 10'd0;
                    byte_ld   = 1'b1;
                    byte_idx  = 4'd0;
                end else begin
                    cnt_nxt = cnt + 10'd1;
                end
            end
            S_LOAD: begin
                if (cnt[3:0] == 4'd15) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = 10'd0;
                end else begin
                    cnt_nxt  = cnt + 10'd1;
                    byte_ld  = 1'b1;
                    byte_idx = cnt[3:0] + 4'd1;
                end
            end
            S_WAIT: begin
                // A rising d_vld takes priority over an expiring timeout in the same cycle.
                if (vld_rise) begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                    cnt_nxt   = 10'd0;
                end else if (cnt == TO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = S_IDLE;
                    cnt_nxt   = 10'd0;
                end else begin
                    cnt_nxt = cnt + 10'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 10'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 10'd0;
            key_reg   <= 128'd0;
            data_reg  <= 128'd0;
            key_byte  <= 8'd0;
            data_byte <= 8'd0;
            vld_prev  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                key_reg  <= in_key;
                data_reg <= in_data;
            end
            if (byte_ld) begin
                key_byte  <= pick_byte(key_reg, byte_idx);
                data_byte <= pick_byte(data_reg, byte_idx);
            end else begin
                key_byte  <= 8'd0;
                data_byte <= 8'd0;
            end
            // Tracking d_vld through CRST/LOAD means a level already high at WAIT entry is not an edge.
            vld_prev <= (state == S_IDLE) ? 1'b0 : core_vld;
        end
    end

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign core_rst = (state == S_IDLE) || (state == S_CRST);
    assign load_act = (state == S_LOAD);

endmodule

// File: tb/tb_aes_byte_loader.sv
// Bench for aes_byte_loader: two instances (MSB-first/long timeout, LSB-first/short timeout)
// driven from a vector table plus random transactions, checked cycle by cycle against a model.
module tb_aes_byte_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [127:0] in_key;
    logic [127:0] in_data;
    logic         in_valid  [2];
    logic         core_vld  [2];
    logic         in_ready  [2];
    logic         core_rst  [2];
    logic         load_act  [2];
    logic         done      [2];
    logic         timeout   [2];
    logic         busy      [2];
    logic [7:0]   key_byte  [2];
    logic [7:0]   data_byte [2];

    int checks   = 0;
    int failures = 0;

    aes_byte_loader #(.RST_CYC(3), .TIMEOUT(250), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_key(in_key), .in_data(in_data), .core_rst(core_rst[0]),
        .key_byte(key_byte[0]), .data_byte(data_byte[0]), .load_act(load_act[0]),
        .core_vld(core_vld[0]), .done(done[0]), .timeout(timeout[0]), .busy(busy[0])
    );

    aes_byte_loader #(.RST_CYC(2), .TIMEOUT(50), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_key(in_key), .in_data(in_data), .core_rst(core_rst[1]),
        .key_byte(key_byte[1]), .data_byte(data_byte[1]), .load_act(load_act[1]),
        .core_vld(core_vld[1]), .done(done[1]), .timeout(timeout[1]), .busy(busy[1])
    );

    function automatic int rc_of(input int s);
        return (s == 0) ? 3 : 2;
    endfunction

    function automatic int to_of(input int s);
        return (s == 0) ? 250 : 50;
    endfunction

    // Byte i of a block in the instance's streaming order.
    function automatic logic [7:0] exp_byte(input logic [127:0] blk, input int i, input int s);
        if (s == 0) return blk[127 - 8 * i -: 8];
        return blk[8 * i +: 8];
    endfunction

    task automatic chk1(input string nm, input int s, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t: got %b expected %b", nm, s, $time, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input int s, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, s, $time, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic drive_junk(input int s, input bit junk);
        if (junk) begin
            in_valid[s] = 1'($urandom_range(0, 1));
            in_key      = {$urandom, $urandom, $urandom, $urandom};
            in_data     = {$urandom, $urandom, $urandom, $urandom};
        end else begin
            in_valid[s] = 1'b0;
        end
    endtask

    task automatic chk_reset_state(input int s);
        chk1("rst_ready", s, in_ready[s], 1'b1);
        chk1("rst_core_rst", s, core_rst[s], 1'b1);
        chk1("rst_load_act", s, load_act[s], 1'b0);
        chk1("rst_busy", s, busy[s], 1'b0);
        chk1("rst_done", s, done[s], 1'b0);
        chk1("rst_timeout", s, timeout[s], 1'b0);
        chk8("rst_key_byte", s, key_byte[s], 8'h00);
        chk8("rst_data_byte", s, data_byte[s], 8'h00);
    endtask

    // One full transaction. result: 1 = done seen, 0 = timeout seen, 2 = aborted by reset, 3 = neither.
    task automatic run_txn(input int s, input logic [127:0] k, input logic [127:0] d, input int dly,
                           input bit junk, input bit pre_high, input int abort_at, output int result);
        int rc, to, eff, last;
        rc     = rc_of(s);
        to     = to_of(s);
        result = 3;
        @(negedge clk);
        core_vld[s] = 1'b0;
        chk1("idle_ready", s, in_ready[s], 1'b1);
        chk1("idle_busy", s, busy[s], 1'b0);
        chk1("idle_core_rst", s, core_rst[s], 1'b1);
        chk1("idle_done", s, done[s], 1'b0);
        in_valid[s] = 1'b1;
        in_key      = k;
        in_data     = d;
        for (int c = 0; c < rc; c++) begin
            @(negedge clk);
            chk1("crst_core_rst", s, core_rst[s], 1'b1);
            chk1("crst_ready", s, in_ready[s], 1'b0);
            chk1("crst_load_act", s, load_act[s], 1'b0);
            drive_junk(s, junk);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk1("load_core_rst", s, core_rst[s], 1'b0);
            chk1("load_act", s, load_act[s], 1'b1);
            chk1("load_busy", s, busy[s], 1'b1);
            chk8("key_byte", s, key_byte[s], exp_byte(k, i, s));
            chk8("data_byte", s, data_byte[s], exp_byte(d, i, s));
            if (pre_high && i == 8) core_vld[s] = 1'b1;
            if (i == abort_at) begin
                in_valid[s] = 1'b0;
                rst_n = 1'b0;
                #1;
                chk_reset_state(s);
                @(negedge clk);
                chk1("rst_hold_ready", s, in_ready[s], 1'b1);
                rst_n  = 1'b1;
                result = 2;
                return;
            end
            drive_junk(s, junk);
        end
        eff  = pre_high ? 1000000 : dly;
        last = (eff < to) ? eff : to;
        for (int kk = 1; kk <= last; kk++) begin
            @(negedge clk);
            if (kk == eff) core_vld[s] = 1'b1;
            #1;
            chk1("wait_done", s, done[s], kk == eff);
            chk1("wait_timeout", s, timeout[s], (kk == to) && (kk != eff));
            chk1("wait_core_rst", s, core_rst[s], 1'b0);
            chk1("wait_load_act", s, load_act[s], 1'b0);
            chk1("wait_ready", s, in_ready[s], 1'b0);
            chk8("wait_key_byte", s, key_byte[s], 8'h00);
            if (kk == last) begin
                if (done[s] === 1'b1) result = 1;
                else if (timeout[s] === 1'b1) result = 0;
                in_valid[s] = 1'b0;
            end else begin
                drive_junk(s, junk);
            end
        end
    endtask

    typedef struct {
        int           s;
        logic [127:0] k;
        logic [127:0] d;
        int           dly;
        bit           junk;
        bit           pre_high;
        int           abort_at;
        int           exp_res;
    } vec_t;

    vec_t tbl[10];

    task automatic set_vec(input int idx, input int s, input logic [127:0] k, input logic [127:0] d,
                           input int dly, input bit junk, input bit pre_high, input int abort_at,
                           input int exp_res);
        tbl[idx].s        = s;
        tbl[idx].k        = k;
        tbl[idx].d        = d;
        tbl[idx].dly      = dly;
        tbl[idx].junk     = junk;
        tbl[idx].pre_high = pre_high;
        tbl[idx].abort_at = abort_at;
        tbl[idx].exp_res  = exp_res;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] fk, fp;
        int res;
        fk = 128'h000102030405060708090a0b0c0d0e0f;
        fp = 128'h00112233445566778899aabbccddeeff;
        set_vec(0, 0, fk, fp, 200, 1'b0, 1'b0, -1, 1);
        set_vec(1, 0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734, 5, 1'b0, 1'b0, -1, 1);
        set_vec(2, 0, 128'hdeadbeef0123456789abcdeffedcba98, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 10, 1'b1, 1'b0, -1, 1);
        set_vec(3, 1, fk, fp, 60, 1'b0, 1'b0, -1, 0);
        set_vec(4, 1, 128'h11111111222222223333333344444444, 128'h55555555666666667777777788888888, 50, 1'b0, 1'b0, -1, 1);
        set_vec(5, 1, 128'hffeeddccbbaa99887766554433221100, 128'h0123456789abcdef0123456789abcdef, 1, 1'b0, 1'b0, -1, 1);
        set_vec(6, 1, 128'ha5a5a5a55a5a5a5aa5a5a5a55a5a5a5a, 128'hc3c3c3c33c3c3c3cc3c3c3c33c3c3c3c, 0, 1'b0, 1'b1, -1, 0);
        set_vec(7, 0, fk, fp, 20, 1'b0, 1'b0, 5, 2);
        set_vec(8, 0, fp, fk, 3, 1'b0, 1'b0, -1, 1);
        set_vec(9, 1, fp, fk, 49, 1'b1, 1'b0, -1, 1);

        rst_n   = 1'b0;
        in_key  = '0;
        in_data = '0;
        for (int s = 0; s < 2; s++) begin
            in_valid[s] = 1'b0;
            core_vld[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) chk_reset_state(s);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i].s, tbl[i].k, tbl[i].d, tbl[i].dly, tbl[i].junk, tbl[i].pre_high,
                    tbl[i].abort_at, res);
            if (tbl[i].abort_at < 0) chki($sformatf("vec%0d_result", i), res, tbl[i].exp_res);
        end

        for (int n = 0; n < 8; n++) begin
            int           s, dly;
            bit           junk;
            logic [127:0] k, d;
            s    = int'($urandom_range(0, 1));
            dly  = int'($urandom_range(1, to_of(s) + 20));
            junk = 1'($urandom_range(0, 1));
            k    = {$urandom, $urandom, $urandom, $urandom};
            d    = {$urandom, $urandom, $urandom, $urandom};
            run_txn(s, k, d, dly, junk, 1'b0, -1, res);
            chki($sformatf("rand%0d_result", n), res, (dly <= to_of(s)) ? 1 : 0);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
